// File: rtl/brightness_ctrl_pkg.sv
// Shared definitions for the brightness control path: the common level width
// (also used by the PWM stage) and the range clamp applied to every level source.
package brightness_ctrl_pkg;

  localparam int LEVEL_W = 10;

  typedef logic [LEVEL_W-1:0] level_t;

  function automatic level_t clamp_level(input level_t x, input level_t lo, input level_t hi);
    if (x < lo)      return lo;
    else if (x > hi) return hi;
    else             return x;
  endfunction

endpackage

// File: rtl/light_avg.sv
// Block averager for the ambient-light sensor: sums 2**AVG_LOG2 samples and
// publishes their clamped mean on avg_reg once the block is complete.
module light_avg
  import brightness_ctrl_pkg::*;
#(
  parameter int AVG_LOG2  = 3,
  parameter int MIN_LEVEL = 16,
  parameter int MAX_LEVEL = 1000
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   sample_valid,
  input  level_t sample,
  output level_t avg_reg
);

  // Wide enough for 2**AVG_LOG2 full-scale samples, so the sum cannot wrap.
  localparam int ACC_W = LEVEL_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** AVG_LOG2) - 1);
  localparam level_t LO = level_t'(MIN_LEVEL);
  localparam level_t HI = level_t'(MAX_LEVEL);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] mean_wide;
  level_t           mean;

  assign sum       = acc + ACC_W'(sample);
  assign mean_wide = sum >> AVG_LOG2;
  assign mean      = mean_wide[LEVEL_W-1:0];

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      cnt     <= '0;
      avg_reg <= LO;
    end else if (sample_valid) begin
      if (cnt == CNT_LAST) begin
        avg_reg <= clamp_level(mean, LO, HI);
        acc     <= '0;
        cnt     <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/brightness_ctrl.sv
// Brightness level generator for the PWM stage: selects the averaged sensor or
// the host value, clamps it, and slews level_pwm toward it one LSB per tick.
module brightness_ctrl
  import brightness_ctrl_pkg::*;
#(
  parameter int AVG_LOG2  = 3,
  parameter int STEP_DIV  = 1000,
  parameter int MIN_LEVEL = 16,
  parameter int MAX_LEVEL = 1000
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   sample_valid,
  input  level_t sample,
  input  logic   manual_en,
  input  level_t manual_level,
  output level_t level_pwm,
  output level_t target,
  output logic   settled
);

  if (MIN_LEVEL > MAX_LEVEL) begin : g_bad_limits
    $error("brightness_ctrl: MIN_LEVEL must not exceed MAX_LEVEL");
  end
  if (MAX_LEVEL >= (2 ** LEVEL_W)) begin : g_bad_max
    $error("brightness_ctrl: MAX_LEVEL does not fit in LEVEL_W bits");
  end
  if (STEP_DIV < 1) begin : g_bad_div
    $error("brightness_ctrl: STEP_DIV must be at least 1");
  end

  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam level_t LO = level_t'(MIN_LEVEL);
  localparam level_t HI = level_t'(MAX_LEVEL);

  level_t           avg_reg;
  logic [PRE_W-1:0] prescaler;
  logic             tick;

  light_avg #(
    .AVG_LOG2 (AVG_LOG2),
    .MIN_LEVEL(MIN_LEVEL),
    .MAX_LEVEL(MAX_LEVEL)
  ) u_light_avg (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample      (sample),
    .avg_reg     (avg_reg)
  );

  // Free-running; target changes never restart it, so step spacing stays regular.
  assign tick = (prescaler == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prescaler <= '0;
    else       prescaler <= tick ? '0 : prescaler + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          target <= LO;
    else if (manual_en) target <= clamp_level(manual_level, LO, HI);
    else                target <= avg_reg;
  end

  // Slew compares against the pre-edge target, so a redirect lands on the next tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_pwm <= '0;
    end else if (tick) begin
      if (level_pwm < target)      level_pwm <= level_pwm + 1'b1;
      else if (level_pwm > target) level_pwm <= level_pwm - 1'b1;
    end
  end

  assign settled = (level_pwm == target);

endmodule

// File: tb/tb_brightness_ctrl.sv
// Randomised scoreboard bench for brightness_ctrl against a behavioural model
// built from sample lists, cycle counts and plain arithmetic.
module tb_brightness_ctrl;

  localparam int AVG_LOG2  = 3;
  localparam int STEP_DIV  = 4;
  localparam int MIN_LEVEL = 16;
  localparam int MAX_LEVEL = 1000;
  localparam int N_AVG     = 1 << AVG_LOG2;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_valid;
  logic [9:0] sample;
  logic       manual_en;
  logic [9:0] manual_level;
  logic [9:0] level_pwm;
  logic [9:0] target;
  logic       settled;

  brightness_ctrl #(
    .AVG_LOG2 (AVG_LOG2),
    .STEP_DIV (STEP_DIV),
    .MIN_LEVEL(MIN_LEVEL),
    .MAX_LEVEL(MAX_LEVEL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample      (sample),
    .manual_en   (manual_en),
    .manual_level(manual_level),
    .level_pwm   (level_pwm),
    .target      (target),
    .settled     (settled)
  );

  always #5 clk = ~clk;

  typedef struct {
    int level;
    int tgt;
    int stl;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state.
  int m_cycles;
  int m_level;
  int m_target;
  int m_avg;
  int m_samples[$];

  function automatic int clamp(input int x);
    if (x < MIN_LEVEL) return MIN_LEVEL;
    if (x > MAX_LEVEL) return MAX_LEVEL;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cycles = 0;
    m_level  = 0;
    m_target = MIN_LEVEL;
    m_avg    = MIN_LEVEL;
    m_samples.delete();
  endtask

  // Expected state after the coming clock edge, given the inputs just driven.
  task automatic model_step(input bit sv, input int s, input bit men, input int ml);
    bit   tick;
    int   nl;
    int   sum;
    exp_t e;
    tick = (m_cycles % STEP_DIV) == (STEP_DIV - 1);
    m_cycles++;
    nl = m_level;
    if (tick && m_level < m_target) nl = m_level + 1;
    if (tick && m_level > m_target) nl = m_level - 1;
    m_target = men ? clamp(ml) : m_avg;
    m_level  = nl;
    if (sv) begin
      m_samples.push_back(s);
      if (m_samples.size() == N_AVG) begin
        sum = 0;
        foreach (m_samples[i]) sum += m_samples[i];
        m_avg = clamp(sum / N_AVG);
        m_samples.delete();
      end
    end
    e.level = m_level;
    e.tgt   = m_target;
    e.stl   = (m_level == m_target) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge; drives inputs for the next rising edge.
  task automatic cyc(input bit sv, input int s, input bit men, input int ml);
    sample_valid = sv;
    sample       = 10'(s);
    manual_en    = men;
    manual_level = 10'(ml);
    model_step(sv, s, men, ml);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit men, input int ml);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, men, ml);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"},   32'(level_pwm), 32'd0);
    check({tag, "_target"},  32'(target),    32'(MIN_LEVEL));
    check({tag, "_settled"}, 32'(settled),   32'd0);
  endtask

  // Reset pulse off the clock grid; returns at a falling edge with reset released.
  task automatic async_reset();
    #3;
    reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    model_reset();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every rising edge outside reset yields one expected state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("level_pwm", 32'(level_pwm), 32'(e.level));
        check("target",    32'(target),    32'(e.tgt));
        check("settled",   32'(settled),   32'(e.stl));
      end
    end
  end

  initial begin
    bit men;
    int ml;
    int guard;
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample       = '0;
    manual_en    = 1'b0;
    manual_level = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_state("initial_reset");
    reset = 1'b0;

    // Fade up to MIN_LEVEL in auto mode, then hold.
    idle(80, 1'b0, 0);

    // Manual targets, including both clamp boundaries.
    idle(760, 1'b1, 200);
    idle(12, 1'b1, 1023);
    idle(12, 1'b1, 3);
    idle(12, 1'b1, MIN_LEVEL);
    idle(12, 1'b1, MAX_LEVEL);

    // Mid-ramp reversal: ramp toward 300, redirect to 50 at level 180.
    idle(4, 1'b1, 100);
    guard = 0;
    while (m_level != 100 && guard < 4000) begin cyc(1'b0, 0, 1'b1, 100); guard++; end
    guard = 0;
    while (m_level != 180 && guard < 4000) begin cyc(1'b0, 0, 1'b1, 300); guard++; end
    idle(600, 1'b1, 50);

    // Auto averaging: back-to-back valids, then gapped valids.
    for (int i = 0; i < N_AVG; i++) cyc(1'b1, 400, 1'b0, 0);
    idle(3, 1'b0, 0);
    for (int i = 0; i < N_AVG; i++) begin
      cyc(1'b1, 400, 1'b0, 0);
      idle(2, 1'b0, 0);
    end

    // Manual 700 then release back to the completed average of 400.
    idle(60, 1'b1, 700);
    idle(80, 1'b0, 0);

    // Seven samples only: target must not move.
    for (int i = 0; i < N_AVG - 1; i++) cyc(1'b1, 800, 1'b0, 0);
    idle(20, 1'b0, 0);

    // Reset mid-ramp and mid-average, then a fresh post-reset average.
    async_reset();
    for (int i = 0; i < N_AVG; i++) cyc(1'b1, 40 * i + 100, 1'b0, 0);
    idle(40, 1'b0, 0);

    // Randomised traffic across modes and sample rates.
    men = 1'b0;
    ml  = $urandom_range(0, 1023);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) men = ~men;
      if ($urandom_range(0, 49) == 0) ml = $urandom_range(0, 1023);
      if (i == 2500) async_reset();
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1023), men, ml);
    end
    idle(4, 1'b0, 0);

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
